// File: rtl/execute_stage_md.sv
// execute_stage_md: RV32 EX stage with operand forwarding, single-cycle ALU,
// iterative M-extension multiply/divide unit and a stallable/flushable EX/MEM register.
module execute_stage_md #(
    parameter int XLEN       = 32,
    parameter int RFWD_SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_ID,
    input  logic                  regFileWe_ID,
    input  logic [RFWD_SEL_W-1:0] RFWDSrcMuxSel_ID,
    input  logic                  busWe_ID,
    input  logic                  aluSrcMuxSel_ID,
    input  logic [3:0]            aluControl_ID,
    input  logic                  mdEn_ID,
    input  logic [2:0]            mdOp_ID,
    input  logic [XLEN-1:0]       instrCode_ID,
    input  logic [XLEN-1:0]       RFData1_ID,
    input  logic [XLEN-1:0]       RFData2_ID,
    input  logic [XLEN-1:0]       immExt_ID,
    input  logic [XLEN-1:0]       PC_4_AdderResult_ID,
    input  logic [XLEN-1:0]       PC_Imm_AdderResult_ID,
    input  logic [XLEN-1:0]       RFWDSrcMuxOut_WB,
    input  logic [1:0]            Forward1,
    input  logic [1:0]            Forward2,
    input  logic                  flush_EXE,
    input  logic                  memStall,
    output logic                  exStall,
    output logic                  valid_EXE,
    output logic                  regFileWe_EXE,
    output logic [RFWD_SEL_W-1:0] RFWDSrcMuxSel_EXE,
    output logic                  busWe_EXE,
    output logic [XLEN-1:0]       instrCode_EXE,
    output logic [XLEN-1:0]       aluResult_EXE,
    output logic [XLEN-1:0]       RFData2_EXE,
    output logic [XLEN-1:0]       immExt_EXE,
    output logic [XLEN-1:0]       PC_Imm_AdderResult_EXE,
    output logic [XLEN-1:0]       PC_4_AdderResult_EXE
);
    localparam int CW = $clog2(XLEN + 1);
    localparam int SW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   op_a, op_b, alu_b, alu_y, md_y, quo, rem, res;
    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] prod;
    logic              start, sa, sb;

    assign op_a  = Forward1 == 2'b01 ? aluResult_EXE : Forward1 == 2'b10 ? RFWDSrcMuxOut_WB : RFData1_ID;
    assign op_b  = Forward2 == 2'b01 ? aluResult_EXE : Forward2 == 2'b10 ? RFWDSrcMuxOut_WB : RFData2_ID;
    assign alu_b = aluSrcMuxSel_ID ? immExt_ID : op_b;

    always_comb begin
        alu_y = '0;
        case (aluControl_ID)
            4'b0000: alu_y = op_a + alu_b;
            4'b1000: alu_y = op_a - alu_b;
            4'b0001: alu_y = op_a << alu_b[SW-1:0];
            4'b0010: alu_y = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(alu_b)};
            4'b0011: alu_y = {{(XLEN-1){1'b0}}, op_a < alu_b};
            4'b0100: alu_y = op_a ^ alu_b;
            4'b0101: alu_y = op_a >> alu_b[SW-1:0];
            4'b1101: alu_y = $signed(op_a) >>> alu_b[SW-1:0];
            4'b0110: alu_y = op_a | alu_b;
            4'b0111: alu_y = op_a & alu_b;
            default: alu_y = '0;
        endcase
    end

    // Operands are latched as magnitudes; signs are restored once in DONE.
    assign sa       = op_a[XLEN-1] & (mdOp_ID == 3'd1 || mdOp_ID == 3'd2 || mdOp_ID == 3'd4 || mdOp_ID == 3'd6);
    assign sb       = op_b[XLEN-1] & (mdOp_ID == 3'd1 || mdOp_ID == 3'd4 || mdOp_ID == 3'd6);
    assign start    = state_q == IDLE && valid_ID && mdEn_ID && !flush_EXE && !reset;
    assign exStall  = start || state_q == BUSY;
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_sh   = {hi_q, lo_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign prod     = sa_q ^ sb_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign quo      = b_q == '0 ? '1 : sa_q ^ sb_q ? -lo_q : lo_q;
    assign rem      = sa_q ? -hi_q : hi_q;
    assign md_y     = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    assign res      = state_q == DONE ? md_y : alu_y;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        op_d    = op_q;
        if (flush_EXE) begin
            state_d = IDLE;
        end else if (!memStall) begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = BUSY;
                    cnt_d   = CW'(XLEN);
                    hi_d    = '0;
                    lo_d    = sa ? -op_a : op_a;
                    b_d     = sb ? -op_b : op_b;
                    sa_d    = sa;
                    sb_d    = sb;
                    op_d    = mdOp_ID;
                end
                BUSY: begin
                    cnt_d   = cnt_q - CW'(1);
                    state_d = cnt_q == CW'(1) ? DONE : BUSY;
                    // div: hi = partial remainder, lo = dividend shifting into quotient; mul: {hi,lo} = product
                    hi_d    = op_q[2] ? (div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0]) : mul_sum[XLEN:1];
                    lo_d    = op_q[2] ? {lo_q[XLEN-2:0], ~div_diff[XLEN]} : {mul_sum[0], lo_q[XLEN-1:1]};
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            op_q    <= op_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_EXE || (!memStall && exStall)) begin
            valid_EXE              <= 1'b0;
            regFileWe_EXE          <= 1'b0;
            RFWDSrcMuxSel_EXE      <= '0;
            busWe_EXE              <= 1'b0;
            instrCode_EXE          <= '0;
            aluResult_EXE          <= '0;
            RFData2_EXE            <= '0;
            immExt_EXE             <= '0;
            PC_Imm_AdderResult_EXE <= '0;
            PC_4_AdderResult_EXE   <= '0;
        end else if (!memStall) begin
            valid_EXE              <= valid_ID;
            regFileWe_EXE          <= regFileWe_ID;
            RFWDSrcMuxSel_EXE      <= RFWDSrcMuxSel_ID;
            busWe_EXE              <= busWe_ID;
            instrCode_EXE          <= instrCode_ID;
            aluResult_EXE          <= res;
            RFData2_EXE            <= op_b;
            immExt_EXE             <= immExt_ID;
            PC_Imm_AdderResult_EXE <= PC_Imm_AdderResult_ID;
            PC_4_AdderResult_EXE   <= PC_4_AdderResult_ID;
        end
    end
endmodule

// File: doc/execute_stage_md.md
Name: execute_stage_md

Overview:
- Parametrised EX stage for the 5-stage RV32 pipeline: forwarding muxes, single-cycle ALU, iterative multiply/divide (RV M-extension) unit, and the EX/MEM pipeline register.
- Adds three controls to the EX/MEM register: stall (hold), flush (bubble) and a valid bit.
- Sits between the ID/EX outputs and the memory stage, and drives a stall request back to the hazard unit.

Parameters:
- XLEN, 32, datapath width; multiply/divide iteration count.
- RFWD_SEL_W, 3, width of the write-back source select.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- valid_ID  in  1  ID/EX slot holds a real instruction
- regFileWe_ID  in  1  register-file write enable
- RFWDSrcMuxSel_ID  in  RFWD_SEL_W  write-back source select
- busWe_ID  in  1  store enable
- aluSrcMuxSel_ID  in  1  0: rs2, 1: immExt
- aluControl_ID  in  4  ALU op, existing alu encoding
- mdEn_ID  in  1  instruction is M-extension
- mdOp_ID  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- instrCode_ID, RFData1_ID, RFData2_ID, immExt_ID, PC_4_AdderResult_ID, PC_Imm_AdderResult_ID  in  XLEN each  ID/EX data
- RFWDSrcMuxOut_WB  in  XLEN  write-back forward value
- Forward1, Forward2  in  2  00: RF, 01: aluResult_EXE, 10: WB, 11: RF
- flush_EXE  in  1  squash the current EX instruction
- memStall  in  1  downstream hold
- exStall  out  1  EX busy; hazard unit holds PC, IF/ID and ID/EX
- valid_EXE, regFileWe_EXE, RFWDSrcMuxSel_EXE, busWe_EXE  out  EX/MEM control
- instrCode_EXE, aluResult_EXE, RFData2_EXE, immExt_EXE, PC_Imm_AdderResult_EXE, PC_4_AdderResult_EXE  out  XLEN  EX/MEM data

Behaviour:
- Reset:
  - All EX/MEM outputs are 0.
  - FSM is IDLE, the iteration counter is 0, and exStall is 0.
- Operands:
  - opA = fwd1(RFData1_ID); opB = fwd2(RFData2_ID).
  - The ALU b input is immExt_ID when aluSrcMuxSel_ID = 1, otherwise opB.
  - RFData2_EXE captures the forwarded opB, not the raw register value.
- Non-M instruction: result = ALU output, registered in one cycle (latency 1).
- MD FSM:
  - States are IDLE, BUSY and DONE. The FSM advances only when memStall = 0.
  - IDLE to BUSY: valid_ID & mdEn_ID. The cycle of acceptance (T) latches the operand magnitudes, sign flags and mdOp, loads counter = XLEN, and asserts exStall combinationally.
  - BUSY: one shift-add (mul, 2*XLEN product) or restoring-subtract (div) step per cycle; counter decrements. When counter reaches 1, go to DONE.
  - DONE: sign correction is applied, exStall = 0, and the EX/MEM register loads the result at the end of the cycle. Next state is IDLE.
  - The held ID/EX instruction is not re-accepted in DONE.
  - exStall is high for cycles T..T+XLEN (XLEN+1 cycles). The result appears on aluResult_EXE at T+XLEN+2.
- MD results:
  - MUL returns the low XLEN bits of the product; MULH/MULHSU/MULHU return the high XLEN bits. Signedness follows RISC-V.
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = dividend.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0.
  - Remainder sign follows the dividend; the quotient is negative when the operand signs differ.
- EX/MEM register priority: reset > flush_EXE > memStall > exStall > normal.
  - flush_EXE: load a bubble (valid, We and busWe = 0; data = 0) and force the FSM to IDLE (abort).
  - memStall: all EX/MEM outputs hold and the FSM freezes in its current state, including DONE.
  - exStall: load a bubble so the MEM stage never sees a duplicated instruction.
  - Normal: load ID/EX values. valid_EXE = valid_ID.
- valid_ID = 0 and mdEn_ID = 1: the FSM stays IDLE and no stall is raised.
- Reset mid-operation: the FSM returns to IDLE on the next edge and no partial result is written.

Test Plan:
- ADD with Forward1 = 01 (aluResult_EXE = 5) and RFData2 = 3 -> aluResult_EXE = 8 one cycle later; with Forward2 = 10 and WB = 9 -> RFData2_EXE = 9.
- DIVU 100/7 -> exStall high for exactly 33 cycles and bubbles in EX/MEM; then aluResult_EXE = 14 with valid_EXE = 1 once. REMU on the same operands -> 2.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0. DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0. MULHU on the same operands -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF. MUL 6 x 7 -> 42.
- flush_EXE at BUSY cycle 10 -> bubble loaded, exStall low next cycle, FSM IDLE, no result ever emitted. Flush asserted together with memStall -> flush wins.
- memStall for 4 cycles during DONE -> EX/MEM held, result loaded the first cycle memStall drops. Reset asserted mid-BUSY -> all outputs 0 and exStall 0 after the edge.
